ysyx_25020037_hzu: RTL and testbench

Hazard/scoreboard controller between the decode stage and the execute stage of the ysyx_25020037 core. It tracks in-flight GPR and CSR writes, stalls decode on RAW/WAW hazards and on capacity limits, and serialises `fence.i`/`ebreak`/`ecall`/`mret` by draining the pipe. Decode hands this block its candidate instruction; execute/writeback report retirements and kills back to it.

---
 rtl/ysyx_25020037_hzu.sv | 132 +++++++++++++
 tb/tb_ysyx_25020037_hzu.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020037_hzu.sv
// Hazard/scoreboard controller between decode and execute: tracks in-flight GPR/CSR
// writes, stalls decode on RAW/WAW/capacity hazards and serialises fence.i/ebreak/ecall/mret.
module ysyx_25020037_hzu #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic [3:0]  dec_rs1,
  input  logic [3:0]  dec_rs2,
  input  logic        dec_use_rs1,
  input  logic        dec_use_rs2,
  input  logic [3:0]  dec_rd,
  input  logic        dec_gpr_we,
  input  logic        dec_csr_rd,
  input  logic        dec_csr_we,
  input  logic        dec_serialize,
  input  logic        exu_ready,
  input  logic        retire_valid,
  input  logic [3:0]  retire_rd,
  input  logic        retire_gpr_we,
  input  logic        retire_csr_we,
  input  logic        kill_valid,
  input  logic [3:0]  kill_rd,
  input  logic        kill_gpr_we,
  input  logic        kill_csr_we,
  output logic        stall,
  output logic        issue_fire,
  output logic [15:0] busy_vec,
  output logic [2:0]  inflight_cnt,
  output logic        err
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SER} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_pend [16];
  logic [1:0]  r_csr_pend;
  logic [2:0]  r_inflight;
  logic        r_err;

  logic [3:0]  w_pend_step [16];
  logic [3:0]  w_csr_step;
  logic [3:0]  w_inf_step;
  logic        w_uf;
  logic        w_raw, w_waw, w_csr, w_cap, w_fsm_stall;

  // Saturating counter step: returns {underflow, next[2:0]}; underflow clamps to 0.
  function automatic logic [3:0] step_cnt(input logic [2:0] cur, input logic inc,
                                          input logic dec_a, input logic dec_b);
    logic [3:0] up, dn, diff;
    up   = {1'b0, cur} + {3'b000, inc};
    dn   = {3'b000, dec_a} + {3'b000, dec_b};
    diff = up - dn;
    if (up < dn) return 4'b1000;
    return {1'b0, diff[2:0]};
  endfunction

  // Hazard detection uses registered counts only; a retire frees its hazard next cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_raw       = 1'b0;
    w_fsm_stall = 1'b1;
    if (dec_use_rs1 && dec_rs1 != 4'd0 && r_pend[dec_rs1] != 2'd0) w_raw = 1'b1;
    if (dec_use_rs2 && dec_rs2 != 4'd0 && r_pend[dec_rs2] != 2'd0) w_raw = 1'b1;
    w_waw = dec_gpr_we && dec_rd != 4'd0 && r_pend[dec_rd] == 2'd3;
    w_csr = (dec_csr_rd || dec_csr_we) && r_csr_pend != 2'd0;
    w_cap = r_inflight == 3'(MAX_INFLIGHT);
    if (r_state == S_RUN) w_fsm_stall = dec_serialize && r_inflight != 3'd0;
    stall      = dec_valid && (w_raw || w_waw || w_csr || w_cap || w_fsm_stall);
    issue_fire = dec_valid && !stall && exu_ready;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN: begin
        if (dec_valid && dec_serialize) begin
          if (r_inflight != 3'd0) w_state_nxt = S_DRAIN;
          else if (issue_fire)    w_state_nxt = S_SER;
        end
      end
      S_DRAIN, S_SER: if (r_inflight == 3'd0) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Issue, retire and kill on the same counter are summed; x0 never matches.
  always_comb begin
    w_uf = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w_pend_step[i] = step_cnt({1'b0, r_pend[i]},
                                issue_fire   && dec_gpr_we    && i != 0 && dec_rd    == 4'(i),
                                retire_valid && retire_gpr_we && i != 0 && retire_rd == 4'(i),
                                kill_valid   && kill_gpr_we   && i != 0 && kill_rd   == 4'(i));
      w_uf = w_uf | w_pend_step[i][3];
    end
    w_csr_step = step_cnt({1'b0, r_csr_pend}, issue_fire && dec_csr_we,
                          retire_valid && retire_csr_we, kill_valid && kill_csr_we);
    w_inf_step = step_cnt(r_inflight, issue_fire, retire_valid, kill_valid);
    w_uf = w_uf | w_csr_step[3] | w_inf_step[3];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the pending-count array is small scoreboard state that must be empty
      // after reset, so unlike a data RAM every entry is reset.
      for (int i = 0; i < 16; i++) r_pend[i] <= 2'd0;
      r_csr_pend <= 2'd0;
      r_inflight <= 3'd0;
      r_state    <= S_RUN;
      r_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      for (int i = 0; i < 16; i++) r_pend[i] <= w_pend_step[i][1:0];
      r_csr_pend <= w_csr_step[1:0];
      r_inflight <= w_inf_step[2:0];
      r_state    <= w_state_nxt;
      r_err      <= r_err | w_uf;
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < 16; i++) busy_vec[i] = r_pend[i] != 2'd0;
  end

  assign inflight_cnt = r_inflight;
  assign err          = r_err;

endmodule

// File: tb/tb_ysyx_25020037_hzu.sv
// Self-checking bench for ysyx_25020037_hzu: directed scenarios plus random traffic,
// compared each cycle against a queue-of-in-flight-instructions reference model.
module tb_ysyx_25020037_hzu;

  localparam int MAXI = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_use_rs1, dec_use_rs2, dec_gpr_we;
  logic        dec_csr_rd, dec_csr_we, dec_serialize, exu_ready;
  logic [3:0]  dec_rs1, dec_rs2, dec_rd;
  logic        retire_valid, retire_gpr_we, retire_csr_we;
  logic        kill_valid, kill_gpr_we, kill_csr_we;
  logic [3:0]  retire_rd, kill_rd;
  logic        stall, issue_fire, err;
  logic [15:0] busy_vec;
  logic [2:0]  inflight_cnt;

  ysyx_25020037_hzu #(.MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd),
    .dec_gpr_we(dec_gpr_we), .dec_csr_rd(dec_csr_rd), .dec_csr_we(dec_csr_we),
    .dec_serialize(dec_serialize), .exu_ready(exu_ready),
    .retire_valid(retire_valid), .retire_rd(retire_rd),
    .retire_gpr_we(retire_gpr_we), .retire_csr_we(retire_csr_we),
    .kill_valid(kill_valid), .kill_rd(kill_rd),
    .kill_gpr_we(kill_gpr_we), .kill_csr_we(kill_csr_we),
    .stall(stall), .issue_fire(issue_fire), .busy_vec(busy_vec),
    .inflight_cnt(inflight_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: the list of issued-but-unretired instructions.
  typedef struct {
    logic [3:0] rd;
    bit         we;
    bit         csr;
  } ent_t;

  ent_t q[$];
  int   mode;      // 0 = normal, 1 = draining before a serialiser, 2 = serialiser in flight
  bit   m_err;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pend_of(input logic [3:0] r);
    int c = 0;
    if (r == 4'd0) return 0;
    foreach (q[k]) if (q[k].we && q[k].rd == r) c++;
    return c;
  endfunction

  function automatic int csr_of();
    int c = 0;
    foreach (q[k]) if (q[k].csr) c++;
    return c;
  endfunction

  function automatic bit m_stall();
    if (!dec_valid) return 1'b0;
    if (dec_use_rs1 && dec_rs1 != 0 && pend_of(dec_rs1) != 0) return 1'b1;
    if (dec_use_rs2 && dec_rs2 != 0 && pend_of(dec_rs2) != 0) return 1'b1;
    if (dec_gpr_we && dec_rd != 0 && pend_of(dec_rd) >= 3) return 1'b1;
    if ((dec_csr_rd || dec_csr_we) && csr_of() != 0) return 1'b1;
    if (q.size() == MAXI) return 1'b1;
    if (mode != 0) return 1'b1;
    if (dec_serialize && q.size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] m_busy();
    logic [15:0] b = '0;
    for (int i = 1; i < 16; i++) b[i] = pend_of(4'(i)) != 0;
    return b;
  endfunction

  task automatic set_dec(input bit v, input logic [3:0] rs1, input bit u1,
                         input logic [3:0] rs2, input bit u2, input logic [3:0] rd,
                         input bit we, input bit crd, input bit cwe, input bit ser);
    dec_valid = v;  dec_rs1 = rs1; dec_use_rs1 = u1; dec_rs2 = rs2; dec_use_rs2 = u2;
    dec_rd = rd;    dec_gpr_we = we; dec_csr_rd = crd; dec_csr_we = cwe; dec_serialize = ser;
  endtask

  // One cycle. rsel/ksel: -1 none, -2 random entry, >=0 queue index; rsel -3 = bogus retire.
  task automatic tick(input int rsel, input int ksel);
    int ri = -1;
    int ki = -1;
    bit bogus = 1'b0;
    bit fire_exp, stall_exp;
    int sz;
    retire_valid = 0; retire_rd = 0; retire_gpr_we = 0; retire_csr_we = 0;
    kill_valid   = 0; kill_rd   = 0; kill_gpr_we   = 0; kill_csr_we   = 0;
    if (rsel == -3) begin
      bogus = 1'b1;
      retire_valid = 1; retire_rd = 4'd5; retire_gpr_we = 1; retire_csr_we = 1;
    end else if (rsel == -2 && q.size() > 0) ri = $urandom_range(0, q.size() - 1);
    else if (rsel >= 0 && rsel < q.size()) ri = rsel;
    if (ksel == -2 && q.size() > ((ri >= 0) ? 1 : 0)) begin
      ki = $urandom_range(0, q.size() - 1);
      if (ki == ri) ki = (ri + 1) % q.size();
    end else if (ksel >= 0 && ksel < q.size() && ksel != ri) ki = ksel;
    if (ri >= 0) begin
      retire_valid = 1; retire_rd = q[ri].rd; retire_gpr_we = q[ri].we; retire_csr_we = q[ri].csr;
    end
    if (ki >= 0) begin
      kill_valid = 1; kill_rd = q[ki].rd; kill_gpr_we = q[ki].we; kill_csr_we = q[ki].csr;
    end
    stall_exp = m_stall();
    fire_exp  = dec_valid && !stall_exp && exu_ready;
    #1;
    check($sformatf("stall@%0d", cyc), stall, stall_exp);
    check($sformatf("fire@%0d", cyc), issue_fire, fire_exp);
    check($sformatf("busy@%0d", cyc), busy_vec, m_busy());
    check($sformatf("cnt@%0d", cyc), inflight_cnt, q.size());
    check($sformatf("err@%0d", cyc), err, m_err);
    @(posedge clk);
    sz = q.size();
    if (mode == 0) begin
      if (dec_valid && dec_serialize && sz != 0) mode = 1;
      else if (fire_exp && dec_serialize) mode = 2;
    end else if (sz == 0) mode = 0;
    if (bogus) m_err = 1'b1;
    if (ri >= 0 && ki >= 0) begin
      q.delete((ri > ki) ? ri : ki);
      q.delete((ri > ki) ? ki : ri);
    end else if (ri >= 0) q.delete(ri);
    else if (ki >= 0) q.delete(ki);
    if (fire_exp) q.push_back('{rd: dec_rd, we: dec_gpr_we, csr: dec_csr_we});
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int g = 0; g < 12 && q.size() > 0; g++) tick(0, -1);
    check("drain_empty", q.size() == 0, 1'b1);
    tick(-1, -1);
  endtask

  initial begin
    rst = 1'b1;
    exu_ready = 1'b1;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    retire_valid = 0; retire_rd = 0; retire_gpr_we = 0; retire_csr_we = 0;
    kill_valid = 0; kill_rd = 0; kill_gpr_we = 0; kill_csr_we = 0;
    mode = 0; m_err = 0;
    #1;
    check("rst_busy", busy_vec, 16'h0);
    check("rst_cnt", inflight_cnt, 3'd0);
    check("rst_err", err, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_fire", issue_fire, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // First issue after reset.
    set_dec(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    #1 check("first_fire", issue_fire, 1'b1);
    tick(-1, -1);
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("first_busy", busy_vec, 16'h0020);
    check("first_cnt", inflight_cnt, 3'd1);
    tick(-1, -1);

    // RAW on x5, x0 source never stalls, retire releases the following cycle.
    set_dec(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 check("raw_stall", stall, 1'b1);
    tick(-1, -1);
    set_dec(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 check("raw_x0", stall, 1'b0);
    tick(-1, -1);
    set_dec(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    tick(0, -1);
    #1 check("raw_release_stall", stall, 1'b0);
    check("raw_release_fire", issue_fire, 1'b1);
    tick(-1, -1);
    drain();

    // WAW cap: fourth write to x3 stalls on pend==3.
    set_dec(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    repeat (3) tick(-1, -1);
    #1 check("waw_stall", stall, 1'b1);
    check("waw_cnt", inflight_cnt, 3'd3);
    tick(-1, -1);
    drain();

    // Capacity: four in flight blocks the fifth until one retires.
    for (int r = 1; r <= 3; r++) begin
      set_dec(1, 0, 0, 0, 0, 4'(r), 1, 0, 0, 0);
      tick(-1, -1);
    end
    set_dec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(-1, -1);
    #1 check("cap_stall", stall, 1'b1);
    check("cap_cnt", inflight_cnt, 3'd4);
    tick(0, -1);
    #1 check("cap_free", issue_fire, 1'b1);
    tick(-1, -1);
    drain();

    // fence.i with two in flight drains, fires, then blocks the following add.
    set_dec(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); tick(-1, -1);
    set_dec(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); tick(-1, -1);
    set_dec(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 check("fence_stall", stall, 1'b1);
    tick(-1, -1);
    tick(0, -1);
    tick(0, -1);
    #1 check("fence_cnt0", inflight_cnt, 3'd0);
    check("fence_still_stall", stall, 1'b1);
    tick(-1, -1);
    #1 check("fence_fire", issue_fire, 1'b1);
    tick(-1, -1);
    set_dec(1, 1, 1, 2, 1, 4, 1, 0, 0, 0);
    #1 check("add_stall", stall, 1'b1);
    tick(-1, -1);
    tick(0, -1);
    for (int g = 0; g < 4 && !issue_fire; g++) tick(-1, -1);
    #1 check("add_fire", issue_fire, 1'b1);
    tick(-1, -1);
    drain();

    // Same-cycle issue and retire on x7; retire plus kill together.
    set_dec(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    tick(-1, -1);
    tick(0, -1);
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("sim_busy7", busy_vec[7], 1'b1);
    check("sim_cnt", inflight_cnt, 3'd1);
    set_dec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(-1, -1);
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 1);
    #1 check("rk_cnt", inflight_cnt, 3'd0);
    tick(-1, -1);

    // Retire with nothing in flight: sticky error, counts stay 0.
    tick(-3, -1);
    #1 check("uf_err", err, 1'b1);
    check("uf_cnt", inflight_cnt, 3'd0);
    check("uf_busy", busy_vec, 16'h0);
    tick(-1, -1);

    // Reset in the middle of a drain with three in flight.
    for (int r = 1; r <= 3; r++) begin
      set_dec(1, 0, 0, 0, 0, 4'(r), 1, 0, 0, 0);
      tick(-1, -1);
    end
    set_dec(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(-1, -1);
    #1 check("mid_stall", stall, 1'b1);
    check("mid_cnt", inflight_cnt, 3'd3);
    rst = 1'b1;
    #1 check("arst_cnt", inflight_cnt, 3'd0);
    check("arst_busy", busy_vec, 16'h0);
    check("arst_err", err, 1'b0);
    check("arst_stall_run", stall, 1'b0);
    dec_valid = 1'b0;
    #1 check("arst_stall", stall, 1'b0);
    check("arst_fire", issue_fire, 1'b0);
    q.delete();
    mode = 0;
    m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    set_dec(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 check("post_rst_fire", issue_fire, 1'b1);
    tick(-1, -1);
    drain();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      set_dec($urandom_range(0, 4) != 0,
              4'($urandom_range(0, 5)), $urandom_range(0, 1) == 1,
              4'($urandom_range(0, 5)), $urandom_range(0, 1) == 1,
              4'($urandom_range(0, 5)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 9) == 0);
      exu_ready = $urandom_range(0, 3) != 0;
      tick(($urandom_range(0, 1) == 1) ? -2 : -1, ($urandom_range(0, 6) == 0) ? -2 : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
